spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one SPI master (2..8).
REQ-002 Parameter SETUP_CYC, default 2, cycles slave-select is held low before the transfer starts (>=1).
REQ-003 Parameter GUARD_CYC, default 2, cycles slave-select is held high after the transfer before ack (>=1).
REQ-004 Parameter TIMEOUT, default 1023, maximum WAIT cycles before abort (10-bit counter).
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester transfer request, level.
REQ-008 req_data  in  8*NREQ  byte to send; slice [8i+7:8i] belongs to requester i.
REQ-009 req_cfg  in  2*NREQ  mode; slice [2i+1] = CPOL, [2i] = CPHA.
REQ-010 gnt  out  NREQ  one-hot, one-cycle pulse: request accepted, data latched.
REQ-011 ack  out  NREQ  one-hot, one-cycle pulse: transfer finished, rsp_data/rsp_err valid.
REQ-012 rsp_data  out  8  received byte; valid while ack is high, held until the next ack.
REQ-013 rsp_err  out  1  timeout flag, qualified by ack.
REQ-014 m_start  out  1  one-cycle start pulse to the SPI master.
REQ-015 m_tx  out  8  byte for the SPI master, stable from SETUP until GUARD.
REQ-016 m_cpol, m_cpha  out  1 each  mode for the SPI master.
REQ-017 m_done  in  1  SPI master completion pulse.
REQ-018 m_rx  in  8  SPI master received byte, valid when m_done=1.
REQ-019 ss_n  out  NREQ  active-low slave selects, at most one low.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, START, WAIT, GUARD, ACK.
REQ-022 IDLE: if any req bit is high, select round-robin starting at (last+1) mod NREQ, latch index/data/cfg, pulse gnt[idx], go to SETUP; else stay.
REQ-023 The last-granted pointer SHALL update only on grant; the reset value is NREQ-1, so requester 0 wins first.
REQ-024 SETUP: ss_n[idx]=0, m_cpol/m_cpha/m_tx driven from latched values, for exactly SETUP_CYC cycles, then START.
REQ-025 START: m_start=1 for one cycle, timeout counter cleared, go to WAIT.
REQ-026 WAIT: on m_done=1 capture m_rx into rsp_data, clear err, go to GUARD; counter increments each cycle otherwise.
REQ-027 WAIT timeout: counter reaching TIMEOUT without m_done sets err=1, rsp_data=8'h00, go to GUARD; m_done on the same cycle SHALL win (no error).
REQ-028 GUARD: all ss_n high for exactly GUARD_CYC cycles, then ACK.
REQ-029 ACK: ack[idx]=1 for one cycle, rsp_err=err, return to IDLE; IDLE may grant on the following cycle.
REQ-030 Latency: req sampled at edge t0 -> gnt at t0+1 -> m_start at t0+1+SETUP_CYC; m_done at td -> ack at td+1+GUARD_CYC.
REQ-031 m_done outside WAIT SHALL be ignored.
REQ-032 req changes after grant SHALL not affect the transfer in progress; a requester re-raising req SHALL wait its round-robin turn.
REQ-033 m_cpol/m_cpha SHALL hold their last granted values in IDLE, so SCLK idle level does not glitch.

Reset
REQ-034 On reset: state IDLE; gnt=0, ack=0, m_start=0, busy=0, rsp_err=0, rsp_data=8'h00, m_tx=8'h00, m_cpol=0, m_cpha=0, ss_n all 1, pointer NREQ-1, counters 0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no ack, and all ss_n SHALL be high by the next cycle.

Verification
REQ-036 Single request: req[2]=1, data 8'hA5, cfg 2'b01, model returns 8'h3C after 16 cycles -> gnt[2] at t0+1, ss_n=4'b1011, m_start at t0+3, m_cpha=1, ack[2] with rsp_data=8'h3C, rsp_err=0.
REQ-037 Fairness: all four req held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3, exactly one gnt and at most one ss_n low at any time.
REQ-038 Timeout: model never asserts m_done -> ack after TIMEOUT+GUARD_CYC cycles past m_start with rsp_err=1, rsp_data=8'h00; the next request completes normally.
REQ-039 Timeout/done tie: m_done on the exact timeout cycle -> rsp_err=0, rsp_data=m_rx.
REQ-040 Reset in WAIT: assert reset for 1 cycle -> ss_n=all 1, busy=0, no ack; with req[0]=1, req[1]=1 after reset, the next grant goes to requester 0.
REQ-041 Spurious m_done in IDLE and in SETUP -> no state change, no ack.

Source files
------------

// File: rtl/spi_arbiter.sv
`timescale 1ns/1ps
// spi_arbiter
// Shares one byte-oriented SPI master between NREQ requesters. Requests are
// served round-robin; each transfer runs SETUP -> START -> WAIT -> GUARD ->
// ACK with the selected slave-select held low from SETUP until WAIT ends.
//
// Handshake semantics (all pulses are single-cycle, registered outputs):
//   req[i] is a level. While the arbiter is IDLE, a high req[i] can be granted.
//   The grant pulses gnt[i] in the first SETUP cycle, and data/cfg are latched
//   on that same edge. Later changes to req/req_data/req_cfg do not affect
//   the transfer. ack[i] pulses once at the end. rsp_data/rsp_err are valid
//   with ack and are held until the next ack. m_start is a one-cycle pulse
//   to the master. m_done is sampled only in WAIT; it is ignored at any
//   other time.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req               per-requester request level        [NREQ]
//   req_data          byte per requester, slice [8i+7:8i] [8*NREQ]
//   req_cfg           {CPOL,CPHA} per requester, [2i+1:2i] [2*NREQ]
//   gnt / ack         one-hot grant / completion pulses  [NREQ]
//   rsp_data/rsp_err  received byte / timeout flag, qualified by ack
//   m_start, m_tx, m_cpol, m_cpha   drive the SPI master
//   m_done, m_rx      completion pulse / received byte from the SPI master
//   ss_n              active-low slave selects, at most one low
//   busy              high in every state except IDLE
//   dbg_state         current FSM state encoding (IDLE = 0)
module spi_arbiter #(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 2,
  parameter int GUARD_CYC = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_cfg,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              m_start,
  output logic [7:0]        m_tx,
  output logic              m_cpol,
  output logic              m_cpha,
  input  logic              m_done,
  input  logic [7:0]        m_rx,
  output logic [NREQ-1:0]   ss_n,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = 16;
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYC - 1);
  // WAIT lasts at most TIMEOUT cycles: the abort fires on the WAIT cycle in
  // which the 10-bit counter would reach TIMEOUT. So between the m_start
  // pulse and the ack pulse lie exactly TIMEOUT WAIT + GUARD_CYC cycles.
  localparam logic [9:0]    TO_LAST    = 10'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GUARD = 3'd4,
    S_ACK   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic              err_q, err_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              m_start_q, m_start_d;
  logic [7:0]        m_tx_q, m_tx_d;
  logic              m_cpol_q, m_cpol_d;
  logic              m_cpha_q, m_cpha_d;
  logic [NREQ-1:0]   ss_n_q, ss_n_d;

  // Round-robin pick: scan from ptr+1 upwards, wrapping, first request wins.
  logic              rr_found;
  logic [IW-1:0]     rr_idx;
  logic [IW-1:0]     rr_cand;
  logic [NREQ-1:0]   rr_onehot;
  logic [7:0]        sel_data;
  logic              sel_cpol;
  logic              sel_cpha;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign rr_onehot = ONE << rr_idx;

  always_comb begin
    sel_data = 8'h00;
    sel_cpol = 1'b0;
    sel_cpha = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_idx == IW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_cpol = req_cfg[2*i+1];
        sel_cpha = req_cfg[2*i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    err_d      = err_q;
    gnt_d      = '0;
    ack_d      = '0;
    m_start_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    m_tx_d     = m_tx_q;
    m_cpol_d   = m_cpol_q;
    m_cpha_d   = m_cpha_q;
    ss_n_d     = ss_n_q;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d  = S_SETUP;
          idx_d    = rr_idx;
          ptr_d    = rr_idx;
          gnt_d    = rr_onehot;
          ss_n_d   = ~rr_onehot;
          m_tx_d   = sel_data;
          m_cpol_d = sel_cpol;
          m_cpha_d = sel_cpha;
          phase_d  = '0;
        end
      end
      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d   = S_START;
          m_start_d = 1'b1;
          phase_d   = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // m_done is checked first so a completion on the abort cycle wins.
        if (m_done) begin
          rx_d    = m_rx;
          err_d   = 1'b0;
          state_d = S_GUARD;
          ss_n_d  = '1;
          phase_d = '0;
        end else if (cnt_q == TO_LAST) begin
          rx_d    = 8'h00;
          err_d   = 1'b1;
          state_d = S_GUARD;
          ss_n_d  = '1;
          phase_d = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_GUARD: begin
        if (phase_q == GUARD_LAST) begin
          state_d    = S_ACK;
          ack_d      = ONE << idx_q;
          rsp_data_d = rx_q;
          rsp_err_d  = err_q;
          phase_d    = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ptr_q      <= IW'(NREQ - 1);
      phase_q    <= '0;
      cnt_q      <= '0;
      rx_q       <= 8'h00;
      err_q      <= 1'b0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      m_start_q  <= 1'b0;
      m_tx_q     <= 8'h00;
      m_cpol_q   <= 1'b0;
      m_cpha_q   <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      m_start_q  <= m_start_d;
      m_tx_q     <= m_tx_d;
      m_cpol_q   <= m_cpol_d;
      m_cpha_q   <= m_cpha_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign m_start   = m_start_q;
  assign m_tx      = m_tx_q;
  assign m_cpol    = m_cpol_q;
  assign m_cpha    = m_cpha_q;
  assign ss_n      = ss_n_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule
